// File: rtl/dac_tone_sequencer_if.sv
// DAC serializer stream: one sample per valid/ready handshake.
interface dac_tone_sequencer_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] dac_data;
   logic              dac_valid;
   logic              dac_ready;

   modport master (output dac_data, output dac_valid, input dac_ready);
   modport slave  (input dac_data, input dac_valid, output dac_ready);
endinterface

// File: rtl/dac_tone_sequencer.sv
// Sine-LUT burst sequencer for the OFDM TX DAC path.
// Walks LUT addresses with a fractional phase accumulator, forwards each
// registered LUT sample over a valid/ready stream and parks at midscale when idle.
// Optional build macro DAC_SEQ_ZERO_CROSS_STOP_EN: a stop-triggered end is
// deferred to the first handshake whose phase add wraps the accumulator.
module dac_tone_sequencer #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       FRAC_W   = 4,
   parameter int unsigned       LEN_W    = 16,
   parameter logic [DATA_W-1:0] MIDSCALE = DATA_W'(8'h80)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W+FRAC_W-1:0] cfg_step,
   input  logic [ADDR_W-1:0]        cfg_phase0,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic                     start,
   input  logic                     stop,
   output logic [ADDR_W-1:0]        lut_addr,
   input  logic [DATA_W-1:0]        lut_data,
   dac_tone_sequencer_if.master     dac,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned ACC_W = ADDR_W + FRAC_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_SHOW  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  step_q, step_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] dac_data_q, dac_data_d;
   logic              dac_valid_q, dac_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;

   logic [ACC_W-1:0]  acc_next_c;
   logic [LEN_W-1:0]  count_inc_c;
   logic              abort_end_c;

`ifdef DAC_SEQ_ZERO_CROSS_STOP_EN
   logic carry_c;

   // Phase advance; an abort only ends the burst on a phase wrap.
   assign {carry_c, acc_next_c} = {1'b0, acc_q} + {1'b0, step_q};
   assign abort_end_c = (abort_q | stop) & carry_c;
`else
   // Phase advance; an abort ends the burst at the next handshake.
   assign acc_next_c  = acc_q + step_q;
   assign abort_end_c = abort_q | stop;
`endif

   assign count_inc_c = count_q + LEN_W'(1);

   // Next-state and output computation for the burst sequencer.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      step_d      = step_q;
      len_d       = len_q;
      count_d     = count_q;
      dac_data_d  = dac_data_q;
      dac_valid_d = dac_valid_q;
      done_d      = 1'b0;
      abort_d     = abort_q;

      if ((state_q != S_IDLE) && stop) begin
         abort_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_len != '0) begin
                  step_d  = cfg_step;
                  len_d   = cfg_len;
                  acc_d   = {cfg_phase0, {FRAC_W{1'b0}}};
                  count_d = '0;
                  state_d = S_FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            dac_data_d  = lut_data;
            dac_valid_d = 1'b1;
            state_d     = S_SHOW;
         end
         S_SHOW: begin
            if (dac.dac_ready) begin
               acc_d       = acc_next_c;
               count_d     = count_inc_c;
               dac_valid_d = 1'b0;
               if ((count_inc_c == len_q) || abort_end_c) begin
                  state_d    = S_IDLE;
                  dac_data_d = MIDSCALE;
                  done_d     = 1'b1;
                  abort_d    = 1'b0;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers, async active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         step_q      <= '0;
         len_q       <= '0;
         count_q     <= '0;
         dac_data_q  <= MIDSCALE;
         dac_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         len_q       <= len_d;
         count_q     <= count_d;
         dac_data_q  <= dac_data_d;
         dac_valid_q <= dac_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
      end
   end

   assign lut_addr      = acc_q[ACC_W-1:FRAC_W];
   assign dac.dac_data  = dac_data_q;
   assign dac.dac_valid = dac_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_dac_tone_sequencer.sv
// Scoreboard bench for dac_tone_sequencer: directed bursts push expected
// (address, sample) pairs; a negedge monitor pops them on every handshake.
module tb_dac_tone_sequencer;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned FRAC_W = 4;
   localparam int unsigned LEN_W  = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } smp_t;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [ADDR_W+FRAC_W-1:0] cfg_step;
   logic [ADDR_W-1:0]        cfg_phase0;
   logic [LEN_W-1:0]         cfg_len;
   logic                     start;
   logic                     stop;
   logic [ADDR_W-1:0]        lut_addr;
   logic [DATA_W-1:0]        lut_data;
   logic                     busy;
   logic                     done;

   logic [DATA_W-1:0] lut_rom [256];

   dac_tone_sequencer_if #(.DATA_W(DATA_W)) dac_if ();

   dac_tone_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_step   (cfg_step),
      .cfg_phase0 (cfg_phase0),
      .cfg_len    (cfg_len),
      .start      (start),
      .stop       (stop),
      .lut_addr   (lut_addr),
      .lut_data   (lut_data),
      .dac        (dac_if.master),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Registered offset-binary sine LUT model (data valid one cycle after address).
   initial begin
      for (int i = 0; i < 256; i++) begin
         real v;
         v = 128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0);
         lut_rom[i] = 8'($rtoi(v + 0.5));
      end
   end

   always @(posedge clk) lut_data <= lut_rom[lut_addr];

   int   checks   = 0;
   int   failures = 0;
   int   hs_cnt   = 0;
   int   done_cnt = 0;
   int   cyc      = 0;
   int   burst_id = 0;
   bit   gap_en   = 1'b0;
   smp_t exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   always @(posedge clk) cyc++;

   // Monitor: pop and compare one expected sample per handshake; count done pulses.
   initial begin
      int prev_cyc;
      int prev_burst;
      prev_cyc   = 0;
      prev_burst = -1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (dac_if.dac_valid === 1'b1 && dac_if.dac_ready === 1'b1) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  fail_now($sformatf("unexpected_sample got 0x%0h", dac_if.dac_data));
               end else begin
                  smp_t e;
                  e = exp_q.pop_front();
                  chk("sample_data", 32'(dac_if.dac_data), 32'(e.data));
                  chk("sample_addr", 32'(lut_addr), 32'(e.addr));
               end
               if (gap_en && prev_burst == burst_id)
                  chk("sample_gap", 32'(cyc - prev_cyc), 32'd3);
               prev_cyc   = cyc;
               prev_burst = burst_id;
            end
            if (done === 1'b1) done_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      smp_t s;
      s.addr = a;
      s.data = d;
      exp_q.push_back(s);
   endtask

   task automatic start_burst(input logic [ADDR_W+FRAC_W-1:0] step,
                              input logic [ADDR_W-1:0] ph0,
                              input logic [LEN_W-1:0] len);
      burst_id++;
      cfg_step   = step;
      cfg_phase0 = ph0;
      cfg_len    = len;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n;
      n = 0;
      while (hs_cnt < target && n < budget) begin
         tick();
         n++;
      end
      if (hs_cnt < target) fail_now("timeout_handshake");
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (dac_if.dac_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (dac_if.dac_valid !== 1'b1) fail_now("timeout_valid");
   endtask

   // Wait for the done pulse and check the parked idle state around it.
   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_midscale"}, 32'(dac_if.dac_data), 32'h80);
      chk({tag, "_valid_at_done"}, 32'(dac_if.dac_valid), 32'd0);
      tick();
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int base;
      int dbase;
      int seen;
      logic [DATA_W-1:0] held;

      rst        = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      cfg_step   = '0;
      cfg_phase0 = '0;
      cfg_len    = '0;
      dac_if.dac_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_lut_addr", 32'(lut_addr), 32'h00);
      chk("rst_dac_data", 32'(dac_if.dac_data), 32'h80);
      chk("rst_dac_valid", 32'(dac_if.dac_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);

      // Basic burst with latency and 3-cycle spacing
      gap_en = 1'b1;
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h01, 8'h83); push(8'h02, 8'h86); push(8'h03, 8'h89);
      start_burst(12'h010, 8'h00, 16'd4);
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_lat0_valid", 32'(dac_if.dac_valid), 32'd0);
      tick();
      chk("basic_lat1_valid", 32'(dac_if.dac_valid), 32'd0);
      tick();
      chk("basic_lat2_valid", 32'(dac_if.dac_valid), 32'd1);
      chk("basic_lat2_data", 32'(dac_if.dac_data), 32'h80);
      wait_done("basic", 40);
      chk("basic_count", 32'(hs_cnt - base), 32'd4);
      chk("basic_queue", 32'(exp_q.size()), 32'd0);

      // Fractional step with accumulator wrap
      base = hs_cnt;
      push(8'hFE, 8'h7A); push(8'hFF, 8'h7D); push(8'h01, 8'h83);
      start_burst(12'h018, 8'hFE, 16'd3);
      wait_done("wrap", 40);
      chk("wrap_count", 32'(hs_cnt - base), 32'd3);

      // Back-pressure on sample 2
      gap_en = 1'b0;
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h01, 8'h83); push(8'h02, 8'h86); push(8'h03, 8'h89);
      start_burst(12'h010, 8'h00, 16'd4);
      wait_hs(base + 1, 20);
      dac_if.dac_ready = 1'b0;
      wait_valid(20);
      held = dac_if.dac_data;
      chk("bp_held_value", 32'(held), 32'h83);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", 32'(dac_if.dac_valid), 32'd1);
         chk("bp_data_held", 32'(dac_if.dac_data), 32'h83);
         chk("bp_addr_held", 32'(lut_addr), 32'h01);
         tick();
      end
      dac_if.dac_ready = 1'b1;
      wait_done("bp", 40);
      chk("bp_count", 32'(hs_cnt - base), 32'd4);

      // Abort with stop coincident with the 3rd handshake
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h40, 8'hFF); push(8'h80, 8'h80);
`ifdef DAC_SEQ_ZERO_CROSS_STOP_EN
      push(8'hC0, 8'h01);
`endif
      start_burst(12'h400, 8'h00, 16'd100);
      wait_hs(base + 2, 20);
      wait_valid(10);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("abort", 40);
`ifdef DAC_SEQ_ZERO_CROSS_STOP_EN
      chk("abort_count", 32'(hs_cnt - base), 32'd4);
`else
      chk("abort_count", 32'(hs_cnt - base), 32'd3);
`endif
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (dac_if.dac_valid === 1'b1 || busy === 1'b1) seen++;
         tick();
      end
      chk("abort_quiet", 32'(seen), 32'd0);

      // Stop pulsed during FETCH is held pending until a handshake
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h40, 8'hFF);
`ifdef DAC_SEQ_ZERO_CROSS_STOP_EN
      push(8'h80, 8'h80); push(8'hC0, 8'h01);
`endif
      start_burst(12'h400, 8'h00, 16'd100);
      wait_hs(base + 1, 20);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("pend", 40);
`ifdef DAC_SEQ_ZERO_CROSS_STOP_EN
      chk("pend_count", 32'(hs_cnt - base), 32'd4);
`else
      chk("pend_count", 32'(hs_cnt - base), 32'd2);
`endif

      // Zero-length start: done only
      base  = hs_cnt;
      start_burst(12'h010, 8'h00, 16'd0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
      chk("len0_done_clear", 32'(done), 32'd0);
      chk("len0_busy_after", 32'(busy), 32'd0);
      chk("len0_no_samples", 32'(hs_cnt - base), 32'd0);

      // Start during a burst is ignored
      gap_en = 1'b1;
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h01, 8'h83); push(8'h02, 8'h86); push(8'h03, 8'h89);
      start_burst(12'h010, 8'h00, 16'd4);
      wait_hs(base + 1, 20);
      cfg_step = 12'h100; cfg_phase0 = 8'h40; cfg_len = 16'd50;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("restart", 40);
      chk("restart_count", 32'(hs_cnt - base), 32'd4);

      // Reset asserted in WAIT
      dbase = done_cnt;
      base  = hs_cnt;
      start_burst(12'h010, 8'h10, 16'd4);
      chk("prerst_addr", 32'(lut_addr), 32'h10);
      tick();
      rst = 1'b1;
      #2;
      chk("midrst_valid", 32'(dac_if.dac_valid), 32'd0);
      chk("midrst_data", 32'(dac_if.dac_data), 32'h80);
      chk("midrst_addr", 32'(lut_addr), 32'h00);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("postrst_no_done", 32'(done_cnt - dbase), 32'd0);
      chk("postrst_no_sample", 32'(hs_cnt - base), 32'd0);

      // Fresh burst after reset behaves as from power-up
      base = hs_cnt;
      push(8'h00, 8'h80); push(8'h01, 8'h83); push(8'h02, 8'h86); push(8'h03, 8'h89);
      start_burst(12'h010, 8'h00, 16'd4);
      tick();
      tick();
      chk("again_lat2_valid", 32'(dac_if.dac_valid), 32'd1);
      wait_done("again", 40);
      chk("again_count", 32'(hs_cnt - base), 32'd4);

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog_timeout (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

endmodule
